cv32e40x_bch_predictor: RTL and testbench
=========================================

# cv32e40x_bch_predictor

Parametrised successor to the ID-stage PC-target unit. It computes the branch and jump targets for JAL, conditional branches and JALR. It adds a dynamic branch predictor: a branch history table (BHT) of 2-bit saturating counters, updated from branch resolution. A static backward-taken/forward-not-taken (BTFN) fallback covers flush and configurations without the BHT. It sits in ID alongside the decoder; resolution feedback comes from EX.

## Interface
Parameters:
- BHT_DEPTH, 64: number of BHT entries; power of two, 2..1024. IDX_W = $clog2(BHT_DEPTH).
- CNT_W, 16: width of the mispredict counter.

Ports (clock and reset first):
- clk  in  1  core clock.
- rst_n  in  1  asynchronous reset, active-low.
- id_valid_i  in  1  valid instruction in ID.
- bch_jmp_mux_sel_i  in  bch_jmp_mux_e  CT_JAL / CT_BCH / CT_JALR.
- pc_id_i  in  32  PC of the ID instruction.
- imm_uj_type_i, imm_sb_type_i, imm_i_type_i  in  32 each  sign-extended immediates.
- jalr_fw_i  in  32  forwarded rs1 for JALR.
- bch_target_o  out  32  branch target.
- jmp_target_o  out  32  jump target.
- bch_prediction_id_o  out  1  branch predicted taken.
- bch_pred_idx_o  out  IDX_W  BHT index used; piped to EX alongside the branch.
- bch_resolve_valid_i  in  1  branch resolved in EX this cycle.
- bch_resolve_idx_i  in  IDX_W  index returned with the resolved branch.
- bch_resolve_taken_i  in  1  actual outcome.
- bch_resolve_mispred_i  in  1  prediction was wrong.
- bht_flush_i  in  1  request re-initialisation of the BHT.
- bht_flush_busy_o  out  1  flush walk in progress.
- mispred_cnt_o  out  CNT_W  saturating mispredict count.

## Operation
- Target selection is combinational:
  - CT_JAL: pc_id_i + imm_uj_type_i.
  - CT_BCH: pc_id_i + imm_sb_type_i.
  - CT_JALR and default: jalr_fw_i + imm_i_type_i.
  - bch_target_o and jmp_target_o are identical; the 32-bit sum wraps modulo 2^32.
- Index is pc_id_i[IDX_W:1] (halfword granularity for compressed instructions).
- Prediction:
  - If id_valid_i && sel==CT_BCH && !bht_flush_busy_o: bch_prediction_id_o = BHT[idx][1].
  - If flushing: bch_prediction_id_o = imm_sb_type_i[31] (BTFN).
  - Otherwise bch_prediction_id_o = 0. It is never latched; there are no inferred latches.
- Counter update on bch_resolve_valid_i while not flushing:
  - If taken: increment, saturating at 2'b11.
  - If not taken: decrement, saturating at 2'b00.
- Flush FSM has two states, IDLE and FLUSH:
  - IDLE -> FLUSH on bht_flush_i; the walk pointer is set to 0.
  - In FLUSH, one entry per cycle is written to 2'b01 and the pointer increments.
  - FLUSH -> IDLE after writing entry BHT_DEPTH-1.
  - bht_flush_busy_o = (state==FLUSH).
  - bht_flush_i asserted while in FLUSH restarts the walk at 0.
  - Resolve updates are dropped while in FLUSH.
- mispred_cnt_o increments on bch_resolve_valid_i && bch_resolve_mispred_i in any state and saturates at all-ones. It is cleared only by reset.

## Timing
- Reset values:
  - All BHT entries 2'b01 (weakly not-taken).
  - FSM in IDLE, walk pointer 0.
  - mispred_cnt_o = 0, bht_flush_busy_o = 0.
  - Combinational outputs follow their inputs.
- Targets, prediction and bch_pred_idx_o have zero latency (same cycle as the ID inputs).
- A BHT update is visible to lookups from the cycle after the resolve edge. A same-cycle lookup and update to the same index returns the pre-update value.
- Flush takes exactly BHT_DEPTH cycles from the first FLUSH cycle. bht_flush_busy_o rises the cycle after bht_flush_i is sampled.
- Reset asserted mid-flush: the FSM returns to IDLE immediately and the entries return to 2'b01.

## Configuration
- CV32E40X_BCH_PREDICT_BHT_EN defined: the BHT, update logic and flush FSM are built as described above.
- Undefined:
  - No BHT storage.
  - The prediction is always BTFN (imm_sb_type_i[31] for a valid CT_BCH, else 0).
  - bht_flush_busy_o is tied to 0, and bht_flush_i, resolve_idx and resolve_taken are ignored.
  - mispred_cnt_o still counts.

## Test plan
- JAL: pc 0x1000, imm_uj 0xFFFFFFF0 -> both targets 0x00000FF0. JALR: fw 0x2001, imm_i 0x3 -> 0x00002004. Wrap: pc 0xFFFFFFFC + imm_sb 8 -> 0x00000004.
- After reset, CT_BCH at pc 0x40 -> prediction 0. Resolve idx 0x20 taken once -> same branch predicts 1. Resolve taken 3 more times -> counter holds 2'b11. Resolve not-taken once -> still predicts 1.
- Same-cycle lookup and taken-update of index 5 from 2'b01 -> that cycle predicts 0, next cycle predicts 1.
- Pulse bht_flush_i -> busy high for exactly 64 cycles. Prediction during busy equals imm_sb[31]. Resolves during busy are dropped. Afterwards all entries read weakly not-taken. Re-pulse at cycle 10 -> busy lasts 64 more cycles from restart.
- With CNT_W=2, five mispredict resolves -> mispred_cnt_o reads 1, 2, 3, 3, 3. Reset mid-count -> 0.
- Build without CV32E40X_BCH_PREDICT_BHT_EN: resolves never change prediction. Negative imm_sb -> 1, positive -> 0. bht_flush_busy_o stays 0.

Source files
------------

// File: rtl/cv32e40x_bch_predictor.sv
// ID-stage branch/jump target unit with a BHT predictor and BTFN fallback; targets and prediction are combinational.
// The BHT and flush walk are built only when CV32E40X_BCH_PREDICT_BHT_EN is defined.
package cv32e40x_bch_pkg;
  typedef enum logic [1:0] {
    CT_NONE = 2'b00,
    CT_JAL  = 2'b01,
    CT_JALR = 2'b10,
    CT_BCH  = 2'b11
  } bch_jmp_mux_e;
endpackage

module cv32e40x_bch_predictor
  import cv32e40x_bch_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  bch_jmp_mux_e     bch_jmp_mux_sel_i,
  input  logic [31:0]      pc_id_i,
  input  logic [31:0]      imm_uj_type_i,
  input  logic [31:0]      imm_sb_type_i,
  input  logic [31:0]      imm_i_type_i,
  input  logic [31:0]      jalr_fw_i,
  output logic [31:0]      bch_target_o,
  output logic [31:0]      jmp_target_o,
  output logic             bch_prediction_id_o,
  output logic [IDX_W-1:0] bch_pred_idx_o,
  input  logic             bch_resolve_valid_i,
  input  logic [IDX_W-1:0] bch_resolve_idx_i,
  input  logic             bch_resolve_taken_i,
  input  logic             bch_resolve_mispred_i,
  input  logic             bht_flush_i,
  output logic             bht_flush_busy_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  logic [31:0] target;
  logic        is_bch;

  always_comb begin
    target = jalr_fw_i + imm_i_type_i;
    case (bch_jmp_mux_sel_i)
      CT_JAL:  target = pc_id_i + imm_uj_type_i;
      CT_BCH:  target = pc_id_i + imm_sb_type_i;
      default: target = jalr_fw_i + imm_i_type_i;
    endcase
  end

  assign bch_target_o   = target;
  assign jmp_target_o   = target;
  assign bch_pred_idx_o = pc_id_i[IDX_W:1];
  assign is_bch         = id_valid_i && (bch_jmp_mux_sel_i == CT_BCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_cnt_o <= '0;
    end else if (bch_resolve_valid_i && bch_resolve_mispred_i && (mispred_cnt_o != '1)) begin
      mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end

`ifdef CV32E40X_BCH_PREDICT_BHT_EN
  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} flush_state_e;

  flush_state_e     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]       bht_q [BHT_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // A flush request in FLUSH restarts the walk from entry 0.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bht_flush_i) begin
          state_d = FLUSH;
          ptr_d   = '0;
        end
      end
      FLUSH: begin
        if (bht_flush_i) begin
          ptr_d = '0;
        end else if (ptr_q == IDX_W'(BHT_DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    bht_flush_busy_o = (state_q == FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (state_q == FLUSH) begin
      bht_q[ptr_q] <= 2'b01;
    end else if (bch_resolve_valid_i) begin
      if (bch_resolve_taken_i) begin
        if (bht_q[bch_resolve_idx_i] != 2'b11) begin
          bht_q[bch_resolve_idx_i] <= bht_q[bch_resolve_idx_i] + 2'b01;
        end
      end else if (bht_q[bch_resolve_idx_i] != 2'b00) begin
        bht_q[bch_resolve_idx_i] <= bht_q[bch_resolve_idx_i] - 2'b01;
      end
    end
  end

  // While the table is being rewritten its contents are stale; fall back to BTFN.
  always_comb begin
    bch_prediction_id_o = 1'b0;
    if (is_bch) begin
      bch_prediction_id_o = bht_flush_busy_o ? imm_sb_type_i[31] : bht_q[bch_pred_idx_o][1];
    end
  end
`else
  logic unused_bht_inputs;

  assign unused_bht_inputs   = ^{bht_flush_i, bch_resolve_idx_i, bch_resolve_taken_i};
  assign bht_flush_busy_o    = 1'b0;
  assign bch_prediction_id_o = is_bch && imm_sb_type_i[31];
`endif

endmodule

// File: tb/tb_cv32e40x_bch_predictor.sv
// Directed bench for cv32e40x_bch_predictor; checks both builds depending on CV32E40X_BCH_PREDICT_BHT_EN.
module tb_cv32e40x_bch_predictor;
  import cv32e40x_bch_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         id_valid;
  bch_jmp_mux_e sel;
  logic [31:0]  pc, imm_uj, imm_sb, imm_i, jalr_fw;
  logic         res_vld, res_taken, res_mis, flush;
  logic [5:0]   res_idx;

  logic [31:0]  bch_tgt, jmp_tgt, bch_tgt2, jmp_tgt2;
  logic         pred, pred2, busy, busy2;
  logic [5:0]   pidx, pidx2;
  logic [15:0]  mcnt;
  logic [1:0]   mcnt2;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  cv32e40x_bch_predictor #(.BHT_DEPTH(64), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .bch_jmp_mux_sel_i(sel),
    .pc_id_i(pc), .imm_uj_type_i(imm_uj), .imm_sb_type_i(imm_sb), .imm_i_type_i(imm_i),
    .jalr_fw_i(jalr_fw), .bch_target_o(bch_tgt), .jmp_target_o(jmp_tgt),
    .bch_prediction_id_o(pred), .bch_pred_idx_o(pidx),
    .bch_resolve_valid_i(res_vld), .bch_resolve_idx_i(res_idx),
    .bch_resolve_taken_i(res_taken), .bch_resolve_mispred_i(res_mis),
    .bht_flush_i(flush), .bht_flush_busy_o(busy), .mispred_cnt_o(mcnt)
  );

  cv32e40x_bch_predictor #(.BHT_DEPTH(64), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .bch_jmp_mux_sel_i(sel),
    .pc_id_i(pc), .imm_uj_type_i(imm_uj), .imm_sb_type_i(imm_sb), .imm_i_type_i(imm_i),
    .jalr_fw_i(jalr_fw), .bch_target_o(bch_tgt2), .jmp_target_o(jmp_tgt2),
    .bch_prediction_id_o(pred2), .bch_pred_idx_o(pidx2),
    .bch_resolve_valid_i(res_vld), .bch_resolve_idx_i(res_idx),
    .bch_resolve_taken_i(res_taken), .bch_resolve_mispred_i(res_mis),
    .bht_flush_i(flush), .bht_flush_busy_o(busy2), .mispred_cnt_o(mcnt2)
  );

  typedef struct {
    bch_jmp_mux_e sel;
    logic         vld;
    logic [31:0]  pc, uj, sb, ii, fw, tgt;
    logic [5:0]   idx;
    logic         pred_bht, pred_btfn;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(bch_jmp_mux_e s, logic v, logic [31:0] p, logic [31:0] uj,
                              logic [31:0] sb, logic [31:0] ii, logic [31:0] fw,
                              logic [31:0] t, logic [5:0] ix, logic pb, logic pf);
    vec_t r;
    r.sel = s; r.vld = v; r.pc = p; r.uj = uj; r.sb = sb; r.ii = ii; r.fw = fw;
    r.tgt = t; r.idx = ix; r.pred_bht = pb; r.pred_btfn = pf;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bch(input logic [31:0] p, input logic [31:0] s);
    id_valid = 1'b1;
    sel      = CT_BCH;
    pc       = p;
    imm_sb   = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = mk(CT_JAL,  1, 32'h0000_1000, 32'hFFFF_FFF0, 32'h100, 32'h200, 32'h3000, 32'h0000_0FF0, 6'h00, 0, 0);
    vecs[1] = mk(CT_JALR, 1, 32'h0000_0044, 32'h10, 32'h20, 32'h3, 32'h2001, 32'h0000_2004, 6'h22, 0, 0);
    vecs[2] = mk(CT_BCH,  1, 32'hFFFF_FFFC, 32'h40, 32'h8, 32'h50, 32'h60, 32'h0000_0004, 6'h3E, 0, 0);
    vecs[3] = mk(CT_BCH,  1, 32'h0000_0100, 32'h70, 32'hFFFF_FFE0, 32'h80, 32'h90, 32'h0000_00E0, 6'h00, 0, 1);
    vecs[4] = mk(CT_NONE, 1, 32'h0000_0020, 32'h11, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h10, 32'h0, 6'h10, 0, 0);
    vecs[5] = mk(CT_JAL,  1, 32'h8000_0000, 32'h8000_0000, 32'h4, 32'h8, 32'hC, 32'h0, 6'h00, 0, 0);
    vecs[6] = mk(CT_JALR, 1, 32'h0000_0002, 32'h5, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 6'h01, 0, 0);
    vecs[7] = mk(CT_BCH,  0, 32'h0000_0010, 32'h1, 32'hFFFF_FFF0, 32'h2, 32'h3, 32'h0, 6'h08, 0, 0);

    rst_n = 1'b0; id_valid = 1'b0; sel = CT_NONE; pc = '0; imm_uj = '0; imm_sb = '0;
    imm_i = '0; jalr_fw = '0; res_vld = 1'b0; res_idx = '0; res_taken = 1'b0;
    res_mis = 1'b0; flush = 1'b0;
    #1;
    chk("rst_mcnt", 32'(mcnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel; id_valid = vecs[i].vld; pc = vecs[i].pc; imm_uj = vecs[i].uj;
      imm_sb = vecs[i].sb; imm_i = vecs[i].ii; jalr_fw = vecs[i].fw;
      #1;
      chk($sformatf("bch_tgt[%0d]", i), bch_tgt, vecs[i].tgt);
      chk($sformatf("jmp_tgt[%0d]", i), jmp_tgt, vecs[i].tgt);
      chk($sformatf("pidx[%0d]", i), 32'(pidx), 32'(vecs[i].idx));
`ifdef CV32E40X_BCH_PREDICT_BHT_EN
      chk($sformatf("pred[%0d]", i), 32'(pred), 32'(vecs[i].pred_bht));
`else
      chk($sformatf("pred[%0d]", i), 32'(pred), 32'(vecs[i].pred_btfn));
`endif
      step();
    end

`ifdef CV32E40X_BCH_PREDICT_BHT_EN
    set_bch(32'h40, 32'h10);
    #1 chk("bht_init", 32'(pred), 32'd0);
    res_vld = 1; res_idx = 6'h20; res_taken = 1;
    step(); res_vld = 0;
    #1 chk("bht_inc", 32'(pred), 32'd1);
    for (int k = 0; k < 3; k++) begin
      res_vld = 1; step(); res_vld = 0;
      #1 chk("bht_sat_inc", 32'(pred), 32'd1);
    end
    res_vld = 1; res_taken = 0; step(); res_vld = 0;
    #1 chk("bht_dec_from_sat", 32'(pred), 32'd1);
    res_vld = 1; step(); res_vld = 0;
    #1 chk("bht_dec2", 32'(pred), 32'd0);

    set_bch(32'h0A, 32'h10);
    res_vld = 1; res_idx = 6'd5; res_taken = 1;
    #1 chk("same_cycle_pre", 32'(pred), 32'd0);
    step(); res_vld = 0;
    #1 chk("same_cycle_post", 32'(pred), 32'd1);
    res_vld = 1; step(); res_vld = 0;

    flush = 1;
    #1 chk("busy_pre", 32'(busy), 32'd0);
    step(); flush = 0; res_vld = 1; res_idx = 6'd7; res_taken = 1;
    #1 chk("busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      imm_sb = n[0] ? 32'hFFFF_FFF0 : 32'h10;
      #1 chk("flush_btfn", 32'(pred), 32'(n[0]));
      step();
    end
    res_vld = 0;
    chk("flush_len", 32'(n), 32'd64);
    for (int i = 0; i < 64; i++) begin
      set_bch(32'(i * 2), 32'h10);
      #1 chk($sformatf("flush_entry[%0d]", i), 32'(pred), 32'd0);
    end

    flush = 1; step(); flush = 0;
    for (int k = 0; k < 10; k++) step();
    flush = 1; step(); flush = 0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    chk("reflush_len", 32'(n), 32'd64);

    set_bch(32'h12, 32'h10);
    res_vld = 1; res_idx = 6'd9; res_taken = 1;
    step(); res_vld = 0;
    #1 chk("pre_rst_bht", 32'(pred), 32'd1);
`else
    set_bch(32'h40, 32'h10);
    res_idx = 6'h20; res_taken = 1;
    for (int k = 0; k < 3; k++) begin
      res_vld = 1; step(); res_vld = 0;
      #1 chk("btfn_fwd", 32'(pred), 32'd0);
    end
    imm_sb = 32'hFFFF_FF80;
    #1 chk("btfn_back", 32'(pred), 32'd1);
    flush = 1; step(); flush = 0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("busy_tied", 32'(busy), 32'd0);
      step();
    end
`endif

    res_vld = 1; res_mis = 1; res_taken = 0; res_idx = '0; flush = 1;
    for (int k = 0; k < 5; k++) begin
      step(); flush = 0;
      #1;
      chk("mcnt_sat", 32'(mcnt2), (k < 2) ? 32'(k + 1) : 32'd3);
      chk("mcnt_wide", 32'(mcnt), 32'(k + 1));
    end
`ifdef CV32E40X_BCH_PREDICT_BHT_EN
    chk("busy_mid", 32'(busy), 32'd1);
`endif
    res_vld = 0; res_mis = 0;
    rst_n = 0;
    #1;
    chk("rst_mcnt_wide", 32'(mcnt), 32'd0);
    chk("rst_mcnt_sat", 32'(mcnt2), 32'd0);
    chk("rst_busy_mid", 32'(busy), 32'd0);
    step(); rst_n = 1;
`ifdef CV32E40X_BCH_PREDICT_BHT_EN
    set_bch(32'h12, 32'h10);
    #1 chk("rst_bht", 32'(pred), 32'd0);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
